// File: rtl/gcd_requester.sv
// Requester front-end for a serial-load GCD engine: accepts operand pairs,
// loads the engine, waits for done, returns the result. Option: GCD_REQ_TIMEOUT_EN.
module gcd_requester #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDA,
    S_LDB,
    S_WAIT,
    S_RSP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_b;

`ifdef GCD_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wd_cnt;
  logic          err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Sequencer with all handshake/engine outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_b      <= '0;
      req_ready <= 1'b1;
      gcd_start <= 1'b0;
      gcd_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_gcd   <= '0;
      busy      <= 1'b0;
`ifdef GCD_REQ_TIMEOUT_EN
      wd_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_b      <= req_b;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_a == '0 || req_b == '0) begin
              // Zero operand: gcd is the other one, no engine needed
              state     <= S_RSP;
              rsp_valid <= 1'b1;
              rsp_gcd   <= (req_a == '0) ? req_b : req_a;
`ifdef GCD_REQ_TIMEOUT_EN
              err_q     <= 1'b0;
`endif
            end else begin
              state     <= S_LDA;
              gcd_start <= 1'b1;
              gcd_data  <= req_a;
            end
          end
        end
        S_LDA: begin
          state     <= S_LDB;
          gcd_start <= 1'b0;
          gcd_data  <= op_b;
        end
        S_LDB: begin
          state <= S_WAIT;
`ifdef GCD_REQ_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (gcd_done) begin
            state     <= S_RSP;
            rsp_valid <= 1'b1;
            rsp_gcd   <= gcd_result;
            gcd_data  <= '0;
`ifdef GCD_REQ_TIMEOUT_EN
            err_q     <= 1'b0;
          end else if (wd_cnt == WD_LAST) begin
            // Engine never answered: report an error result
            state     <= S_RSP;
            rsp_valid <= 1'b1;
            rsp_gcd   <= '0;
            gcd_data  <= '0;
            err_q     <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          gcd_start <= 1'b0;
          gcd_data  <= '0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester: the bench plays both the requester's
// client and the GCD engine, with hand-computed expected values.
module tb_gcd_requester;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         gcd_start;
  logic [W-1:0] gcd_data;
  logic         gcd_done;
  logic [W-1:0] gcd_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_gcd;
  logic         rsp_err;
  logic         busy;

  int tests = 0;
  int fails = 0;

  gcd_requester #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .gcd_start (gcd_start),
    .gcd_data  (gcd_data),
    .gcd_done  (gcd_done),
    .gcd_result(gcd_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_gcd   (rsp_gcd),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_start"}, 32'(gcd_start), 32'd0);
    chk({tag, "_data"}, 32'(gcd_data), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    gcd_done = 1'b0;
    gcd_result = '0;
    rsp_ready = 1'b0;
    step();
    step();
    chk_idle("rst");
    chk("rst_gcd", 32'(rsp_gcd), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;

    // stray done while idle must be ignored
    gcd_done = 1'b1;
    gcd_result = 16'd77;
    step();
    chk_idle("idle_done");
    gcd_done = 1'b0;

    // 48,18 -> 6 with done on the 5th wait cycle
    req_valid = 1'b1;
    req_a = 16'd48;
    req_b = 16'd18;
    step();
    req_valid = 1'b0;
    chk("lda_start", 32'(gcd_start), 32'd1);
    chk("lda_data", 32'(gcd_data), 32'd48);
    chk("lda_busy", 32'(busy), 32'd1);
    chk("lda_ready", 32'(req_ready), 32'd0);
    step();
    chk("ldb_start", 32'(gcd_start), 32'd0);
    chk("ldb_data", 32'(gcd_data), 32'd18);
    step();
    for (int i = 1; i <= 5; i++) begin
      chk("wait_valid", 32'(rsp_valid), 32'd0);
      chk("wait_start", 32'(gcd_start), 32'd0);
      chk("wait_data", 32'(gcd_data), 32'd18);
      if (i == 5) begin
        gcd_done = 1'b1;
        gcd_result = 16'd6;
      end
      step();
    end
    gcd_done = 1'b0;
    chk("rsp8_valid", 32'(rsp_valid), 32'd1);
    chk("rsp8_gcd", 32'(rsp_gcd), 32'd6);
    chk("rsp8_err", 32'(rsp_err), 32'd0);
    chk("rsp8_data", 32'(gcd_data), 32'd0);

    // backpressure: result held, new request waits
    req_valid = 1'b1;
    req_a = 16'd0;
    req_b = 16'd35;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_gcd", 32'(rsp_gcd), 32'd6);
      chk("hold_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rel_valid", 32'(rsp_valid), 32'd0);
    chk("rel_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("byp35_valid", 32'(rsp_valid), 32'd1);
    chk("byp35_gcd", 32'(rsp_gcd), 32'd35);
    chk("byp35_start", 32'(gcd_start), 32'd0);
    chk("byp35_err", 32'(rsp_err), 32'd0);

    // done while in response must not disturb the result
    gcd_done = 1'b1;
    gcd_result = 16'd99;
    step();
    gcd_done = 1'b0;
    chk("rspdone_gcd", 32'(rsp_gcd), 32'd35);

    // 0,0 -> 0
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_a = 16'd0;
    req_b = 16'd0;
    step();
    req_valid = 1'b0;
    chk("byp00_valid", 32'(rsp_valid), 32'd1);
    chk("byp00_gcd", 32'(rsp_gcd), 32'd0);

    // 9,0 -> 9
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_a = 16'd9;
    req_b = 16'd0;
    step();
    req_valid = 1'b0;
    chk("byp90_valid", 32'(rsp_valid), 32'd1);
    chk("byp90_gcd", 32'(rsp_gcd), 32'd9);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // reset while waiting on the engine
    req_valid = 1'b1;
    req_a = 16'd100;
    req_b = 16'd75;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    chk("prerst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("midrst");
    for (int i = 0; i < 4; i++) begin
      chk("postrst_valid", 32'(rsp_valid), 32'd0);
      step();
    end

    // 21,14 -> 7 with immediate done
    req_valid = 1'b1;
    req_a = 16'd21;
    req_b = 16'd14;
    step();
    req_valid = 1'b0;
    chk("r2_lda", 32'(gcd_data), 32'd21);
    step();
    chk("r2_ldb", 32'(gcd_data), 32'd14);
    step();
    chk("r2_wait", 32'(rsp_valid), 32'd0);
    gcd_done = 1'b1;
    gcd_result = 16'd7;
    step();
    gcd_done = 1'b0;
    chk("r2_valid", 32'(rsp_valid), 32'd1);
    chk("r2_gcd", 32'(rsp_gcd), 32'd7);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk_idle("r2_done");

`ifdef GCD_REQ_TIMEOUT_EN
    // engine silent: error after 16 wait cycles
    req_valid = 1'b1;
    req_a = 16'd5;
    req_b = 16'd10;
    step();
    req_valid = 1'b0;
    step();
    step();
    for (int i = 1; i <= 16; i++) begin
      chk("to_wait", 32'(rsp_valid), 32'd0);
      step();
    end
    chk("to_valid", 32'(rsp_valid), 32'd1);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_gcd", 32'(rsp_gcd), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // done on the limit cycle wins
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    for (int i = 1; i <= 16; i++) begin
      chk("tod_wait", 32'(rsp_valid), 32'd0);
      if (i == 16) begin
        gcd_done = 1'b1;
        gcd_result = 16'd5;
      end
      step();
    end
    gcd_done = 1'b0;
    chk("tod_valid", 32'(rsp_valid), 32'd1);
    chk("tod_err", 32'(rsp_err), 32'd0);
    chk("tod_gcd", 32'(rsp_gcd), 32'd5);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`else
    // without the watchdog a silent engine keeps the block waiting
    req_valid = 1'b1;
    req_a = 16'd5;
    req_b = 16'd10;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("nto_valid", 32'(rsp_valid), 32'd0);
    chk("nto_busy", 32'(busy), 32'd1);
    gcd_done = 1'b1;
    gcd_result = 16'd5;
    step();
    gcd_done = 1'b0;
    chk("nto_gcd", 32'(rsp_gcd), 32'd5);
    chk("nto_err", 32'(rsp_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
